multicycle_div: RTL and testbench
=================================

Name: multicycle_div

Overview:
- Iterative radix-2 restoring divider in the execute stage.
- Consumes the ALU operand pair after the operand-B select: srca = rs1 value, srcb = selected operand B (register value for divide ops).
- Serves DIV/DIVU/REM/REMU and the W variants; stalls the pipeline through a valid/ready handshake.
- Results go to the execute/memory pipeline register.

Parameters:
XLEN, 64, datapath width; W ops use the low 32 bits.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of the in-flight op
valid_in  in  1  request; operands and op fields are valid
ready_in  out  1  high only in IDLE; request accepted on valid_in&ready_in
is_signed  in  1  signed op (DIV/REM/DIVW/REMW)
is_rem  in  1  return remainder instead of quotient
is_word  in  1  32-bit op, result sign-extended to XLEN
srca  in  XLEN  dividend
srcb  in  XLEN  divisor
valid_out  out  1  result valid; held until out_ready
out_ready  in  1  consumer accepts result
result  out  XLEN  quotient or remainder

Behaviour:
- Reset (resetn=0, async): state=IDLE; valid_out=0, result=0, ready_in=1 once released. Reset mid-operation discards all internal state.
- States:
  - IDLE: on accept, latch is_signed/is_rem/is_word and operands; go to PREP.
  - PREP (1 cycle):
    - W ops: take the low 32 bits, sign- or zero-extended per is_signed.
    - Signed ops: record sign of dividend and of quotient (sa^sb); take magnitudes.
    - Detect divide-by-zero (divisor==0) and overflow (signed, dividend = most-negative of the op width, divisor = -1).
    - Go to CALC with counter = N-1.
  - CALC (N cycles, N=XLEN):
    - Each cycle, shift {rem,quo} left 1.
    - If rem >= divisor magnitude: subtract it and set quo[0]=1.
    - Counter decrements; at 0 go to FIX.
  - FIX (1 cycle): apply signs, then apply the special cases; register result, set valid_out=1, go to DONE.
    - Quotient is negated if the quotient sign is 1.
    - Remainder takes the dividend's sign.
  - DONE: hold result and valid_out; on out_ready go to IDLE and clear valid_out in the same edge. No new request is accepted in DONE.
- Latency: accepting edge E0 -> valid_out high after edge E0+N+2 (66 for XLEN=64), for every op including the special cases.
- Special results (RISC-V):
  - Divide-by-zero: quotient = all ones, remainder = dividend.
  - Overflow: quotient = dividend, remainder = 0.
  - For W ops these values are computed on 32 bits, then sign-extended.
- W ops: the final 32-bit result is sign-extended to XLEN regardless of is_signed.
- Flush:
  - Any state -> IDLE at the next edge; valid_out=0; the result register is not updated.
  - flush wins over valid_in in the same cycle: no accept.
  - flush in DONE together with out_ready: IDLE; no double accept.
- Operands and op fields are captured only at accept; later input changes are ignored.

Optional Feature:
- Macro DIV_FAST_EN.
- Defined:
  - W ops iterate N=32; latency 34.
  - Divide-by-zero and overflow skip CALC: PREP goes directly to FIX; latency 2.
- Undefined: fixed latency N+2 = 66 for all ops, as above.

Test Plan:
- DIVU srca=100, srcb=7 -> after 66 cycles valid_out=1, result=14; REMU same operands -> 2; ready_in low throughout the busy period.
- DIV srca=-7 (0xFFFF_FFFF_FFFF_FFF9), srcb=2 -> result=-3 (0xFFFF_FFFF_FFFF_FFFD); REM same -> -1.
- DIV srcb=0, srca=5 -> 0xFFFF_FFFF_FFFF_FFFF; REM -> 5. DIV srca=0x8000_0000_0000_0000, srcb=-1 -> 0x8000_0000_0000_0000; REM -> 0.
- DIVW srca=0x1_8000_0000, srcb=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 (overflow); DIVUW srca=0xFFFF_FFFF, srcb=1 -> 0xFFFF_FFFF_FFFF_FFFF (sign-extended).
- Hold out_ready=0 for 5 cycles after valid_out -> result stable, ready_in=0; out_ready=1 -> next cycle IDLE, valid_out=0.
- flush at cycle 30 of CALC, then resetn pulse low mid-CALC on a second op -> both return to IDLE, valid_out never rises; a subsequent DIVU 9/3 returns 3.
- With DIV_FAST_EN: DIVW 20/3 -> 6 after 34 cycles; DIV by 0 -> valid_out after 2 cycles.

Source files
------------

// File: rtl/multicycle_div.sv
// -----------------------------------------------------------------------------
// multicycle_div
//   Iterative radix-2 restoring divider used by the execute stage for
//   DIV/DIVU/REM/REMU and the 32-bit W variants. A request is taken on
//   valid_in & ready_in, and the pipeline stalls until the result has been
//   handed over through the valid_out / out_ready handshake.
//
//   State sequence: IDLE -> PREP -> CALC (N cycles) -> FIX -> DONE -> IDLE.
//   Latency from the accepting edge to valid_out is N+2 edges, with N = XLEN.
//
//   Optional build macro DIV_FAST_EN:
//     W ops iterate only 32 times, giving a latency of 34.
//     Divide-by-zero and overflow go from PREP straight to FIX, giving a
//     latency of 2.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   flush      synchronous kill of the in-flight op; takes priority over a request
//   valid_in   request; operands and op fields are valid
//   ready_in   high only in IDLE
//   is_signed  signed op (DIV/REM/DIVW/REMW)
//   is_rem     return the remainder instead of the quotient
//   is_word    32-bit op; the result is sign-extended to XLEN
//   srca       dividend (rs1)
//   srcb       divisor (selected operand B)
//   valid_out  result valid; held until out_ready
//   out_ready  consumer accepts the result
//   result     quotient or remainder
// -----------------------------------------------------------------------------
module multicycle_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            valid_in,
  output logic            ready_in,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic            is_word,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            valid_out,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state_reg;
  logic              signed_reg;
  logic              rem_op_reg;
  logic              word_reg;
  logic [XLEN-1:0]   a_reg;       // raw dividend; after PREP, the op-width extended dividend
  logic [XLEN-1:0]   b_reg;       // raw divisor
  logic [XLEN-1:0]   rem_reg;     // partial remainder
  logic [XLEN-1:0]   quo_reg;     // dividend bits shifting out / quotient bits shifting in
  logic [XLEN-1:0]   div_reg;     // divisor magnitude
  logic [CNT_W-1:0]  cnt_reg;
  logic              sa_reg;      // dividend sign, which the remainder takes
  logic              qs_reg;      // quotient sign
  logic              dz_reg;      // divide by zero
  logic              ov_reg;      // signed overflow
  logic              valid_out_reg;
  logic [XLEN-1:0]   result_reg;

  // Sign-extend a 32-bit value to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // ---------------------------------------------------------------------------
  // PREP: operand extension, sign handling and special-case detection.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] min_neg;
  logic            a_neg;
  logic            b_neg;
  logic            prep_dz;
  logic            prep_ov;

  always_comb begin
    a_ext = a_reg;
    b_ext = b_reg;
    if (word_reg) begin
      if (signed_reg) begin
        a_ext = sext32(a_reg[31:0]);
        b_ext = sext32(b_reg[31:0]);
      end else begin
        a_ext = {{(XLEN-32){1'b0}}, a_reg[31:0]};
        b_ext = {{(XLEN-32){1'b0}}, b_reg[31:0]};
      end
    end

    a_neg = signed_reg & a_ext[XLEN-1];
    b_neg = signed_reg & b_ext[XLEN-1];
    // The magnitude of the most-negative value is 2^(XLEN-1), which still fits
    // as an unsigned number, so no extra bit is needed.
    a_mag = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag = b_neg ? (~b_ext + 1'b1) : b_ext;

    // Most-negative value of the op width, as it appears after extension.
    if (word_reg) begin
      min_neg = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end

    prep_dz = (b_ext == '0);
    prep_ov = signed_reg && (a_ext == min_neg) && (b_ext == '1);
  end

  // ---------------------------------------------------------------------------
  // CALC: one restoring step.
  // The shifted remainder needs one extra bit, because it can reach
  // 2*divisor-1. The difference always fits in XLEN bits, so it is formed
  // on XLEN bits directly.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   shifted;
  logic            take;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;

  always_comb begin
    shifted  = {rem_reg, quo_reg[XLEN-1]};
    take     = (shifted >= {1'b0, div_reg});
    rem_step = take ? (shifted[XLEN-1:0] - div_reg) : shifted[XLEN-1:0];
    quo_step = {quo_reg[XLEN-2:0], take};
  end

  // ---------------------------------------------------------------------------
  // FIX: restore signs, override the special cases, then pick the result and
  // narrow it to the op width.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] q_val;
  logic [XLEN-1:0] r_val;
  logic [XLEN-1:0] fix_res;

  always_comb begin
    q_val = qs_reg ? (~quo_reg + 1'b1) : quo_reg;
    r_val = sa_reg ? (~rem_reg + 1'b1) : rem_reg;
    if (dz_reg) begin
      q_val = '1;
      r_val = a_reg;
    end else if (ov_reg) begin
      q_val = a_reg;
      r_val = '0;
    end
    fix_res = rem_op_reg ? r_val : q_val;
    // W results are always sign-extended, whether or not the op is signed.
    if (word_reg) begin
      fix_res = sext32(fix_res[31:0]);
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      signed_reg    <= 1'b0;
      rem_op_reg    <= 1'b0;
      word_reg      <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      div_reg       <= '0;
      cnt_reg       <= '0;
      sa_reg        <= 1'b0;
      qs_reg        <= 1'b0;
      dz_reg        <= 1'b0;
      ov_reg        <= 1'b0;
      valid_out_reg <= 1'b0;
      result_reg    <= '0;
    end else if (flush) begin
      // Kill whatever is in flight. The result register keeps its last value.
      state_reg     <= IDLE;
      valid_out_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (valid_in) begin
            signed_reg <= is_signed;
            rem_op_reg <= is_rem;
            word_reg   <= is_word;
            a_reg      <= srca;
            b_reg      <= srcb;
            state_reg  <= PREP;
          end
        end

        PREP: begin
          a_reg   <= a_ext;
          sa_reg  <= a_neg;
          qs_reg  <= a_neg ^ b_neg;
          dz_reg  <= prep_dz;
          ov_reg  <= prep_ov;
          rem_reg <= '0;
          quo_reg <= a_mag;
          div_reg <= b_mag;
          cnt_reg <= CNT_W'(XLEN - 1);
          state_reg <= CALC;
`ifdef DIV_FAST_EN
          if (word_reg) begin
            // Park the 32-bit magnitude in the top half, so that 32 shifts
            // consume all of it and leave the quotient in the low half.
            quo_reg <= {a_mag[31:0], {(XLEN-32){1'b0}}};
            cnt_reg <= CNT_W'(31);
          end
          if (prep_dz || prep_ov) begin
            state_reg <= FIX;
          end
`endif
        end

        CALC: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            state_reg <= FIX;
          end
        end

        FIX: begin
          result_reg    <= fix_res;
          valid_out_reg <= 1'b1;
          state_reg     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            valid_out_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg     <= IDLE;
          valid_out_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ready_in  = (state_reg == IDLE);
  assign valid_out = valid_out_reg;
  assign result    = result_reg;

endmodule

// File: tb/tb_multicycle_div.sv
// -----------------------------------------------------------------------------
// tb_multicycle_div
//   Directed-vector bench for multicycle_div. The expected results and
//   latencies are hand-computed. Prints one line per transaction and a
//   final summary line.
// -----------------------------------------------------------------------------
module tb_multicycle_div;

  localparam int XLEN = 64;

`ifdef DIV_FAST_EN
  localparam int LAT_SPECIAL = 2;
  localparam int LAT_WORD    = 34;
`else
  localparam int LAT_SPECIAL = XLEN + 2;
  localparam int LAT_WORD    = XLEN + 2;
`endif
  localparam int LAT_FULL = XLEN + 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic            flush;
  logic            valid_in;
  logic            ready_in;
  logic            is_signed;
  logic            is_rem;
  logic            is_word;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            valid_out;
  logic            out_ready;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  multicycle_div #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .is_signed (is_signed),
    .is_rem    (is_rem),
    .is_word   (is_word),
    .srca      (srca),
    .srcb      (srcb),
    .valid_out (valid_out),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input bit word, input bit special);
    int lat;
    lat = LAT_FULL;
    if (special)   lat = LAT_SPECIAL;
    else if (word) lat = LAT_WORD;
    return lat;
  endfunction

  // Issue one op, scramble the inputs after the accept, check the busy window,
  // the latency, the result, an optional out_ready=0 hold period, and the
  // return to IDLE.
  task automatic run_op(input string tag, input bit sg, input bit rm, input bit wd,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                        input bit sp, input int hold);
    int lat;
    bit busy_bad;
    bit hold_bad;
    lat = exp_lat(wd, sp);
    @(negedge clk);
    chk({tag, ":ready_before"}, 64'(ready_in), 64'd1);
    is_signed = sg;
    is_rem    = rm;
    is_word   = wd;
    srca      = a;
    srcb      = b;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    srca      = ~a;
    srcb      = b + 64'd3;
    is_signed = ~sg;
    is_rem    = ~rm;
    is_word   = ~wd;
    busy_bad  = 1'b0;
    for (int k = 1; k < lat; k++) begin
      @(posedge clk);
      #1;
      if (valid_out !== 1'b0 || ready_in !== 1'b0) busy_bad = 1'b1;
    end
    chk({tag, ":busy"}, 64'(busy_bad), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, ":valid"}, 64'(valid_out), 64'd1);
    chk({tag, ":result"}, result, exp);
    hold_bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      if (valid_out !== 1'b1 || ready_in !== 1'b0 || result !== exp) hold_bad = 1'b1;
    end
    if (hold > 0) chk({tag, ":hold"}, 64'(hold_bad), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ":valid_clr"}, 64'(valid_out), 64'd0);
    chk({tag, ":ready_after"}, 64'(ready_in), 64'd1);
    $display("txn %-8s signed=%0d rem=%0d word=%0d a=%h b=%h result=%h expected=%h lat=%0d",
             tag, sg, rm, wd, a, b, result, exp, lat);
  endtask

  // Start DIVU 100/7 and return right after the accepting edge.
  task automatic start_op();
    @(negedge clk);
    is_signed = 1'b0;
    is_rem    = 1'b0;
    is_word   = 1'b0;
    srca      = 64'd100;
    srcb      = 64'd7;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
  endtask

  initial begin
    bit vbad;
    logic [63:0] last_res;

    resetn    = 1'b0;
    flush     = 1'b0;
    valid_in  = 1'b0;
    out_ready = 1'b0;
    is_signed = 1'b0;
    is_rem    = 1'b0;
    is_word   = 1'b0;
    srca      = '0;
    srcb      = '0;
    #1;
    chk("rst:valid_out", 64'(valid_out), 64'd0);
    chk("rst:result", result, 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst:ready_in", 64'(ready_in), 64'd1);

    // Directed vectors
    run_op("divu",   0, 0, 0, 64'd100, 64'd7, 64'd14, 0, 5);
    run_op("remu",   0, 1, 0, 64'd100, 64'd7, 64'd2, 0, 0);
    run_op("div_n",  1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0);
    run_op("rem_n",  1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    run_op("rem_nb", 1, 1, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0, 0);
    run_op("div_z",  1, 0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("rem_z",  1, 1, 0, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("div_ov", 1, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ov", 1, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    run_op("div_mn", 1, 0, 0, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 0, 0);
    run_op("divu_mx",0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0);
    run_op("divw_ov",1, 0, 1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("divuw",  0, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    run_op("divw",   1, 0, 1, 64'd20, 64'd3, 64'd6, 0, 0);
    run_op("remw_n", 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    run_op("divuw_h",0, 0, 1, 64'hDEAD_0000_0000_0010, 64'h1234_0000_0000_0004, 64'd4, 0, 0);
    run_op("remuw_z",0, 1, 1, 64'h0000_0001_8000_0001, 64'hFFFF_FFFF_0000_0000,
           64'hFFFF_FFFF_8000_0001, 1, 0);
    last_res = 64'd4;
    // The result register holds 0xFFFF_FFFF_8000_0001 from the last op.
    last_res = 64'hFFFF_FFFF_8000_0001;

    // Flush at cycle 30 of CALC
    start_op();
    repeat (31) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush:ready_in", 64'(ready_in), 64'd1);
    chk("flush:valid_out", 64'(valid_out), 64'd0);
    vbad = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (valid_out !== 1'b0) vbad = 1'b1;
    end
    chk("flush:quiet", 64'(vbad), 64'd0);
    chk("flush:result_kept", result, last_res);
    $display("txn flush    mid-CALC result=%h", result);

    // Flush together with valid_in in IDLE: no accept
    @(negedge clk);
    srca     = 64'd9;
    srcb     = 64'd3;
    valid_in = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    flush    = 1'b0;
    chk("flush_req:ready_in", 64'(ready_in), 64'd1);
    $display("txn flushreq valid_in with flush ready_in=%0d", ready_in);

    // Asynchronous reset mid-CALC
    start_op();
    repeat (20) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #2;
    chk("arst:result", result, 64'd0);
    chk("arst:valid_out", 64'(valid_out), 64'd0);
    chk("arst:ready_in", 64'(ready_in), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    vbad = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (valid_out !== 1'b0) vbad = 1'b1;
    end
    chk("arst:quiet", 64'(vbad), 64'd0);
    $display("txn reset    mid-CALC result=%h", result);

    run_op("divu93", 0, 0, 0, 64'd9, 64'd3, 64'd3, 0, 0);

    // Flush with out_ready in DONE while a new request is present
    @(negedge clk);
    is_signed = 1'b0;
    is_rem    = 1'b0;
    is_word   = 1'b0;
    srca      = 64'd9;
    srcb      = 64'd3;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (exp_lat(1'b0, 1'b0)) @(posedge clk);
    #1;
    chk("done_flush:valid", 64'(valid_out), 64'd1);
    @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    valid_in  = 1'b0;
    chk("done_flush:valid_clr", 64'(valid_out), 64'd0);
    chk("done_flush:ready_in", 64'(ready_in), 64'd1);
    @(posedge clk);
    #1;
    chk("done_flush:no_accept", 64'(ready_in), 64'd1);
    $display("txn dflush   flush+out_ready in DONE ready_in=%0d", ready_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
